// File: rtl/data_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : data_mem_responder
// Description : Memory-side responder for the CPU data port. Accepts one
//               load/store at a time, performs it on an internal word RAM
//               after WAIT_CYCLES wait states and stalls the pipeline until
//               the response cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] resp_rdata,
  output logic        resp_valid,
  output logic        stall,
  output logic        addr_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  // First value of the down-counter; unused when there are no wait states.
  localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  logic        capture;
  logic        enter_resp;

  // Captured request (word address only; byte offset is irrelevant).
  logic [31:2] cap_addr;
  logic [3:0]  cap_we;
  logic [31:0] cap_wdata;
  logic        cap_oor;

  // Effective access: live inputs when completing straight out of IDLE
  // (WAIT_CYCLES = 0), otherwise the captured request.
  logic [31:2]           acc_addr;
  logic [3:0]            acc_we;
  logic [31:0]           acc_wdata;
  logic                  acc_oor;
  logic [ADDR_WIDTH-1:0] acc_idx;

  logic [31:0] mem [DEPTH];

  // Byte offset bits do not take part in the access.
  logic unused_byte_offset;
  assign unused_byte_offset = ^req_addr[1:0];

  // Select live or captured request and decode range / word index.
  always_comb begin
    acc_addr  = cap_addr;
    acc_we    = cap_we;
    acc_wdata = cap_wdata;
    if (state == IDLE) begin
      acc_addr  = req_addr[31:2];
      acc_we    = req_we;
      acc_wdata = req_wdata;
    end
    acc_oor = |acc_addr[31:ADDR_WIDTH+2];
    acc_idx = acc_addr[ADDR_WIDTH+1:2];
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_resp = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    addr_err   = 1'b0;
    case (state)
      IDLE: begin
        if (req_en) begin
          stall   = 1'b1;
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 3'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RESP: begin
        // The held request is the one completing; req_en is not looked at.
        resp_valid = 1'b1;
        addr_err   = cap_oor;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture the request on acceptance; it stays fixed until completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr  <= '0;
      cap_we    <= 4'd0;
      cap_wdata <= 32'd0;
      cap_oor   <= 1'b0;
    end else if (capture) begin
      cap_addr  <= req_addr[31:2];
      cap_we    <= req_we;
      cap_wdata <= req_wdata;
      cap_oor   <= |req_addr[31:ADDR_WIDTH+2];
    end
  end

  // RAM write on the edge entering RESP; gated by reset so an aborted
  // request never reaches storage.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && (acc_we != 4'd0) && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_we[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data register; holds until the next completed read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata <= 32'd0;
    end else if (enter_resp && (acc_we == 4'd0)) begin
      resp_rdata <= acc_oor ? 32'd0 : mem[acc_idx];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_data_mem_responder
// Description : Directed bench for data_mem_responder. Four instances with
//               WAIT_CYCLES = 0..3 share one clock; a vector table drives
//               single transactions, hand sequences cover reset and
//               protocol-violation corner cases.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_responder;

  localparam int NDUT = 4;

  logic        clk;
  logic        rst        [NDUT];
  logic        req_en     [NDUT];
  logic [3:0]  req_we     [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_valid [NDUT];
  logic        stall      [NDUT];
  logic        addr_err   [NDUT];

  int n_checks = 0;
  int n_fail   = 0;

  // Instance d has WAIT_CYCLES = d.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    data_mem_responder #(
      .ADDR_WIDTH (10),
      .WAIT_CYCLES(g)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_en    (req_en[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_valid(resp_valid[g]),
      .stall     (stall[g]),
      .addr_err  (addr_err[g])
    );
  end

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          dut;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;   // resp_rdata expected in the RESP cycle
    bit          exp_err;
    bit          hold;     // keep req_en high into the next vector
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got 0x%08h, want 0x%08h", name, d, $time, act, exp);
    end
  endtask

  // Called #1 after a rising edge. Checks stall/resp_valid/addr_err every
  // cycle of the transaction and resp_rdata in the RESP cycle.
  task automatic run_req(input int d, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input bit exp_err, input bit hold, input bit drop);
    req_en[d]    = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    for (int c = 0; c <= d + 1; c++) begin
      @(negedge clk);
      check("stall",      d, 32'(stall[d]),      32'(c <= d));
      check("resp_valid", d, 32'(resp_valid[d]), 32'(c == d + 1));
      check("addr_err",   d, 32'(addr_err[d]),   32'((c == d + 1) && exp_err));
      if (c == d + 1) check("resp_rdata", d, resp_rdata[d], exp_rd);
      @(posedge clk);
      #1;
      if (drop && c == 0) begin
        req_en[d]    = 1'b0;
        req_we[d]    = 4'hF;
        req_addr[d]  = addr + 32'd4;
        req_wdata[d] = 32'd0;
      end
    end
    if (!hold) begin
      req_en[d] = 1'b0;
      req_we[d] = 4'h0;
      @(negedge clk);
      check("idle_stall", d, 32'(stall[d]),      32'd0);
      check("idle_valid", d, 32'(resp_valid[d]), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // dut0 (no wait states): basic write/read, range errors, top word.
    vecs.push_back(vec_t'{0, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{0, 4'h0, 32'h0000_0020, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{0, 4'hF, 32'h0000_0000, 32'h55AA_55AA, 32'hDEAD_BEEF, 1'b0, 1'b0});
    vecs.push_back(vec_t'{0, 4'hF, 32'h0000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b0});
    vecs.push_back(vec_t'{0, 4'h0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back(vec_t'{0, 4'h0, 32'h0000_0000, 32'h0,         32'h55AA_55AA, 1'b0, 1'b0});
    vecs.push_back(vec_t'{0, 4'hF, 32'h0000_0FFC, 32'h0BAD_F00D, 32'h55AA_55AA, 1'b0, 1'b0});
    vecs.push_back(vec_t'{0, 4'h0, 32'h0000_0FFF, 32'h0,         32'h0BAD_F00D, 1'b0, 1'b0});
    // dut2: partial-lane writes.
    vecs.push_back(vec_t'{2, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2, 4'h3, 32'h0000_0010, 32'hAABB_CCDD, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2, 4'h0, 32'h0000_0010, 32'h0,         32'h1122_CCDD, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2, 4'hF, 32'h0000_0014, 32'h0000_0000, 32'h1122_CCDD, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2, 4'h8, 32'h0000_0014, 32'hEE77_6655, 32'h1122_CCDD, 1'b0, 1'b0});
    vecs.push_back(vec_t'{2, 4'h0, 32'h0000_0014, 32'h0,         32'hEE00_0000, 1'b0, 1'b0});
    // dut1: back-to-back reads with req_en held high.
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0020, 32'h0000_0A20, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1, 4'hF, 32'h0000_0024, 32'h0000_0B24, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0020, 32'h0,         32'h0000_0A20, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1, 4'h0, 32'h0000_0024, 32'h0,         32'h0000_0B24, 1'b0, 1'b0});
    // dut3: seed word 0x40 before the reset-abort sequence.
    vecs.push_back(vec_t'{3, 4'hF, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{3, 4'h0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0});

    for (int d = 0; d < NDUT; d++) begin
      rst[d]       = 1'b0;
      req_en[d]    = 1'b0;
      req_we[d]    = 4'h0;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
    end

    // Reset values.
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check("rst_rdata", d, resp_rdata[d],        32'd0);
      check("rst_valid", d, 32'(resp_valid[d]),   32'd0);
      check("rst_stall", d, 32'(stall[d]),        32'd0);
      check("rst_err",   d, 32'(addr_err[d]),     32'd0);
    end
    // In reset stall follows req_en combinationally.
    req_en[0] = 1'b1;
    #1;
    check("rst_stall_follow", 0, 32'(stall[0]),      32'd1);
    check("rst_valid_follow", 0, 32'(resp_valid[0]), 32'd0);
    req_en[0] = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) rst[d] = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven transactions.
    foreach (vecs[i]) begin
      run_req(vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              vecs[i].exp_rd, vecs[i].exp_err, vecs[i].hold, 1'b0);
    end

    // Reset during WAIT aborts the pending write of 0 to 0x40 (dut3).
    req_en[3]    = 1'b1;
    req_we[3]    = 4'hF;
    req_addr[3]  = 32'h0000_0040;
    req_wdata[3] = 32'h0000_0000;
    @(negedge clk);
    check("abort_stall_c0", 3, 32'(stall[3]), 32'd1);
    @(posedge clk);
    #1;
    rst[3]    = 1'b0;
    req_en[3] = 1'b0;
    req_we[3] = 4'h0;
    @(negedge clk);
    check("abort_rdata", 3, resp_rdata[3],      32'd0);
    check("abort_valid", 3, 32'(resp_valid[3]), 32'd0);
    check("abort_stall", 3, 32'(stall[3]),      32'd0);
    check("abort_err",   3, 32'(addr_err[3]),   32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst[3] = 1'b1;
    run_req(3, 4'h0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);

    // req_en dropped (and inputs garbled) during WAIT of a read (dut2).
    run_req(2, 4'h0, 32'h0000_0010, 32'h0, 32'h1122_CCDD, 1'b0, 1'b0, 1'b1);
    // The garbled inputs must not have produced a write to 0x14.
    run_req(2, 4'h0, 32'h0000_0014, 32'h0, 32'hEE00_0000, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU data port. It accepts memory-stage requests: byte address, 4-bit byte-write enable, write data and request-valid. It performs the access on an internal word-organised RAM and returns read data after a parameterised number of wait states. While the access is outstanding it drives a stall back to the pipeline. It sits between the pipeline's memory stage and on-chip data storage, replacing a zero-latency combinational memory model.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM depth 2^ADDR_WIDTH words; valid byte range 0 .. 4*2^ADDR_WIDTH-1
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; legal range 0..7
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_en  in  1  request valid (memory-stage load/store); held stable by CPU while stall=1
- req_we  in  4  byte-write enables, bit i = byte lane i (bits [8i+7:8i]); 4'b0000 = read
- req_addr  in  32  byte address; bits [1:0] ignored (word access, lanes selected by req_we)
- req_wdata  in  32  write data, already lane-aligned
- resp_rdata  out  32  read data; valid while resp_valid=1, held until next completed read
- resp_valid  out  1  one-cycle pulse on the completion cycle of every accepted request
- stall  out  1  pipeline stall; high while a request is outstanding and not yet completing
- addr_err  out  1  pulses with resp_valid when the address is out of range

## Operation
- FSM states: IDLE, WAIT, RESP. Down-counter cnt is 3 bits.
- IDLE: when req_en=1, capture req_addr, req_we and req_wdata. Go to RESP if WAIT_CYCLES=0. Otherwise load cnt=WAIT_CYCLES-1 and go to WAIT. When req_en=0, stay in IDLE.
- WAIT: when cnt=0, go to RESP; otherwise cnt decrements.
- RESP: drive resp_valid=1 for exactly one cycle, then go to IDLE. req_en is ignored in RESP, because the held request is the one completing and is not re-accepted.
- The access takes effect on the edge that enters RESP, using the captured values.
- Write (captured we≠0): update only the lanes whose we bit is set; other lanes keep their value. resp_rdata is unchanged.
- Read (captured we=0): resp_rdata ← RAM[addr[ADDR_WIDTH+1:2]].
- Range check: the address is out of range if captured addr[31:ADDR_WIDTH+2]≠0. In that case:
  - the write is suppressed,
  - resp_rdata ← 0 for a read,
  - addr_err=1 in the RESP cycle.
- stall = (state=IDLE & req_en) | (state=WAIT). stall=0 in RESP, so the CPU advances at the end of RESP.
- If req_en falls or the request inputs change during WAIT (protocol violation), the captured request still completes unchanged.
- RAM contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset values: state=IDLE, cnt=0, resp_rdata=0, resp_valid=0, addr_err=0. stall then follows req_en combinationally.
- Latency: request first seen in cycle 0 → resp_valid in cycle 1+WAIT_CYCLES.
- stall is high for exactly 1+WAIT_CYCLES cycles per request.
- Back-to-back: the earliest next acceptance is the cycle after RESP. The start-to-start spacing of consecutive requests is 2+WAIT_CYCLES cycles.
- Reset asserted in IDLE or WAIT: the request is aborted and no RAM write occurs. After reset release, a still-asserted req_en is treated as a new request.
- Reset asserted in RESP: the write has already happened, and outputs return to reset values immediately.
- A read in RESP reflects every write completed in an earlier RESP cycle. There is no read/write hazard, because only one access is in flight at a time.

## Test plan
- WAIT_CYCLES=0: write we=4'hF, addr 0x20, data 0xDEADBEEF, then read 0x20. Required: each request has stall high for 1 cycle and resp_valid in cycle 1; the read returns 0xDEADBEEF.
- WAIT_CYCLES=2: first write 0x11223344 to 0x10. Then write we=4'b0011, data 0xAABBCCDD, to 0x10, then read 0x10. Required: read returns 0x1122CCDD; resp_valid arrives 3 cycles after request; stall high 3 cycles.
- ADDR_WIDTH=10: write 0x12345678 to 0x1000, then read 0x1000. Required: addr_err=1 with resp_valid on both accesses, read data 0, and RAM word 0 unmodified when read at 0x0.
- Back-to-back reads of 0x20 and 0x24 with req_en held high, WAIT_CYCLES=1. Required: resp_valid in cycles 2 and 5, exactly one pulse per request.
- WAIT_CYCLES=3: first write 0xCAFEF00D to 0x40 and complete it. Then issue a write of 0x0 to 0x40, pulse rst low during WAIT, release, and read 0x40. Required: the read returns 0xCAFEF00D; all outputs are 0 during reset.
- Drop req_en during WAIT of a read, WAIT_CYCLES=2. Required: resp_valid still pulses once with the correct data, and the FSM returns to IDLE.
